// File: rtl/btn_debounce.sv
// Button input conditioning for the three PMOD push-buttons.
// Each button is synchronised, debounced against a shared tick prescaler and
// presented as a stable level plus single-cycle press/release pulses.
module btn_debounce #(
  parameter int TICK_DIV     = 12000,
  parameter int STABLE_TICKS = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  output logic [2:0] BTN_LEVEL,
  output logic [2:0] BTN_PRESS,
  output logic [2:0] BTN_RELEASE,
  output logic       TICK
);

  localparam int PC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_TICKS);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    WAIT_H = 2'd1,
    HIGH   = 2'd2,
    WAIT_L = 2'd3
  } state_t;

  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;

  assign raw = {BTN3, BTN2, BTN1};

  // Two-flop synchroniser for the asynchronous button pads
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Next prescaler value, wrapping at TICK_DIV-1
  always_comb begin
    pc_next = pc + PC_W'(1);
    if (pc == PC_LAST) begin
      pc_next = '0;
    end
  end

  // Prescaler; TICK is registered from pc_next so it is high exactly while pc is at its last value
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc   <= '0;
      TICK <= 1'b0;
    end else begin
      pc   <= pc_next;
      TICK <= (pc_next == PC_LAST);
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_btn
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             level;
    logic             press;
    logic             release_p;

    assign cnt_inc        = cnt + CNT_W'(1);
    assign BTN_LEVEL[g]   = level;
    assign BTN_PRESS[g]   = press;
    assign BTN_RELEASE[g] = release_p;

    // Debounce FSM: a change must persist for STABLE_TICKS ticks; reverting aborts the wait
    always_ff @(posedge CLK) begin
      if (RST) begin
        state     <= LOW;
        cnt       <= '0;
        level     <= 1'b0;
        press     <= 1'b0;
        release_p <= 1'b0;
      end else begin
        press     <= 1'b0;
        release_p <= 1'b0;
        case (state)
          LOW: begin
            if (sync2[g]) begin
              state <= WAIT_H;
              cnt   <= '0;
            end
          end
          WAIT_H: begin
            if (!sync2[g]) begin
              state <= LOW;
              cnt   <= '0;
            end else if (TICK) begin
              if (cnt_inc == CNT_DONE) begin
                state <= HIGH;
                cnt   <= '0;
                level <= 1'b1;
                press <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          HIGH: begin
            if (!sync2[g]) begin
              state <= WAIT_L;
              cnt   <= '0;
            end
          end
          WAIT_L: begin
            if (sync2[g]) begin
              state <= HIGH;
              cnt   <= '0;
            end else if (TICK) begin
              if (cnt_inc == CNT_DONE) begin
                state     <= LOW;
                cnt       <= '0;
                level     <= 1'b0;
                release_p <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          default: begin
            state <= LOW;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: a fixed vector table, directed corner sequences and
// random button activity, all checked against a timing-rule reference model.
// Two instances run in parallel: (4,3) and the boundary case (2,1).
module tb_btn_debounce;

  localparam int DIV_A = 4;
  localparam int S_A   = 3;
  localparam int DIV_B = 2;
  localparam int S_B   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = '0;

  logic [2:0] lvl_a, prs_a, rel_a;
  logic [2:0] lvl_b, prs_b, rel_b;
  logic       tick_a, tick_b;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  btn_debounce #(.TICK_DIV(DIV_A), .STABLE_TICKS(S_A)) dut_a (
    .CLK(clk), .RST(rst), .BTN1(btn[0]), .BTN2(btn[1]), .BTN3(btn[2]),
    .BTN_LEVEL(lvl_a), .BTN_PRESS(prs_a), .BTN_RELEASE(rel_a), .TICK(tick_a)
  );

  btn_debounce #(.TICK_DIV(DIV_B), .STABLE_TICKS(S_B)) dut_b (
    .CLK(clk), .RST(rst), .BTN1(btn[0]), .BTN2(btn[1]), .BTN3(btn[2]),
    .BTN_LEVEL(lvl_b), .BTN_PRESS(prs_b), .BTN_RELEASE(rel_b), .TICK(tick_b)
  );

  // ---------------- reference model ----------------
  // Cycle index since reset gives the tick phase directly; a level flips once the
  // synchronised input has differed from it continuously and enough ticks have
  // elapsed after the first differing cycle.
  int         div_m  [2] = '{DIV_A, DIV_B};
  int         stab_m [2] = '{S_A, S_B};
  int         cyc    [2] = '{0, 0};
  logic [2:0] r1_m   [2] = '{3'b0, 3'b0};
  logic [2:0] s_m    [2] = '{3'b0, 3'b0};
  logic [2:0] lvl_m  [2] = '{3'b0, 3'b0};
  logic [2:0] prs_m  [2] = '{3'b0, 3'b0};
  logic [2:0] rel_m  [2] = '{3'b0, 3'b0};
  bit         run_on [2][3];
  int         run_st [2][3];

  // number of tick cycles among cycle indices 0..x
  function automatic int ticks_upto(input int x, input int div);
    return (x + 1) / div;
  endfunction

  function automatic logic tick_exp(input int k);
    return (cyc[k] % div_m[k]) == (div_m[k] - 1);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cyc[k] = 0; r1_m[k] = '0; s_m[k] = '0;
        lvl_m[k] = '0; prs_m[k] = '0; rel_m[k] = '0;
        for (int b = 0; b < 3; b++) run_on[k][b] = 1'b0;
      end else begin
        prs_m[k] = '0;
        rel_m[k] = '0;
        for (int b = 0; b < 3; b++) begin
          if (s_m[k][b] == lvl_m[k][b]) begin
            run_on[k][b] = 1'b0;
          end else if (!run_on[k][b]) begin
            run_on[k][b] = 1'b1;
            run_st[k][b] = cyc[k];
          end else if (ticks_upto(cyc[k], div_m[k]) - ticks_upto(run_st[k][b], div_m[k]) == stab_m[k]) begin
            lvl_m[k][b] = ~lvl_m[k][b];
            if (lvl_m[k][b]) prs_m[k][b] = 1'b1;
            else             rel_m[k][b] = 1'b1;
            run_on[k][b] = 1'b0;
          end
        end
        s_m[k]  = r1_m[k];
        r1_m[k] = btn;
        cyc[k]  = cyc[k] + 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("a_level",   {29'd0, lvl_a}, {29'd0, lvl_m[0]});
    chk("a_press",   {29'd0, prs_a}, {29'd0, prs_m[0]});
    chk("a_release", {29'd0, rel_a}, {29'd0, rel_m[0]});
    chk("a_tick",    {31'd0, tick_a}, {31'd0, tick_exp(0)});
    chk("a_excl",    {29'd0, prs_a & rel_a}, 32'd0);
    chk("b_level",   {29'd0, lvl_b}, {29'd0, lvl_m[1]});
    chk("b_press",   {29'd0, prs_b}, {29'd0, prs_m[1]});
    chk("b_release", {29'd0, rel_b}, {29'd0, rel_m[1]});
    chk("b_tick",    {31'd0, tick_b}, {31'd0, tick_exp(1)});
  endtask

  // drive at a falling edge, let one rising edge pass, check at the next falling edge
  task automatic step(input logic r, input logic [2:0] b);
    rst = r;
    btn = b;
    @(negedge clk);
    check_models();
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] btn;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    logic       tick;
  } vec_t;

  vec_t tbl [27];

  initial begin
    int n;
    int lat;
    int tick_cnt;
    logic bad;
    logic [2:0] seen;
    logic [2:0] b;
    int hold;

    // Table for instance A: BTN1 held over rows 1..12, single-cycle BTN2 glitch at row 16.
    // Row i is applied before rising edge i; edge 0 is the reset edge.
    for (int i = 0; i < 27; i++) begin
      tbl[i].rst  = (i == 0);
      tbl[i].btn  = (i >= 1 && i <= 12) ? 3'b001 : 3'b000;
      tbl[i].lvl  = (i >= 12 && i <= 23) ? 3'b001 : 3'b000;
      tbl[i].prs  = (i == 12) ? 3'b001 : 3'b000;
      tbl[i].rel  = (i == 24) ? 3'b001 : 3'b000;
      tbl[i].tick = (i >= 1) && ((i % 4) == 3);
    end
    tbl[16].btn = 3'b010;

    @(negedge clk);
    for (int i = 0; i < 27; i++) begin
      step(tbl[i].rst, tbl[i].btn);
      chk($sformatf("tbl%0d_level", i),   {29'd0, lvl_a}, {29'd0, tbl[i].lvl});
      chk($sformatf("tbl%0d_press", i),   {29'd0, prs_a}, {29'd0, tbl[i].prs});
      chk($sformatf("tbl%0d_release", i), {29'd0, rel_a}, {29'd0, tbl[i].rel});
      chk($sformatf("tbl%0d_tick", i),    {31'd0, tick_a}, {31'd0, tbl[i].tick});
    end

    // Idle after reset: only TICK moves, once every 4 cycles
    step(1'b1, 3'b000);
    tick_cnt = 0;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 3'b000);
      if (tick_a) tick_cnt++;
      if ((lvl_a | prs_a | rel_a) != 3'b000) bad = 1'b1;
    end
    chk("idle_tick_count", tick_cnt, 25);
    chk("idle_outputs_quiet", {31'd0, bad}, 32'd0);

    // BTN1 rise: level change within the latency window, single press pulse
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 3'b001);
      if (lvl_a[0]) begin lat = i; break; end
    end
    chk("rise_latency_in_window", {31'd0, (lat >= 11 && lat <= 15)}, 32'd1);
    chk("rise_press", {29'd0, prs_a}, 32'd1);
    chk("rise_other_levels", {30'd0, lvl_a[2:1]}, 32'd0);
    step(1'b0, 3'b001);
    chk("rise_press_one_cycle", {29'd0, prs_a}, 32'd0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 3'b000);
      if (!lvl_a[0]) begin n = i; break; end
    end
    chk("fall_seen", {31'd0, (n != 0)}, 32'd1);
    chk("fall_release", {29'd0, rel_a}, 32'd1);

    // BTN2 chatter: 5 high / 3 low, four times; must be rejected
    bad = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        step(1'b0, (i < 5) ? 3'b010 : 3'b000);
        if (lvl_a[1] | prs_a[1] | rel_a[1]) bad = 1'b1;
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 3'b000);
      if (lvl_a[1] | prs_a[1] | rel_a[1]) bad = 1'b1;
    end
    chk("chatter_rejected", {31'd0, bad}, 32'd0);

    // BTN1+BTN3 together: simultaneous press and release pulses
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 3'b101);
      if (prs_a != 3'b000) begin seen = prs_a; break; end
    end
    chk("dual_press", {29'd0, seen}, 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 3'b101);
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 3'b000);
      if (rel_a != 3'b000) begin seen = rel_a; break; end
    end
    chk("dual_release", {29'd0, seen}, 32'd5);
    chk("dual_level_low", {29'd0, lvl_a}, 32'd0);

    // Reset while BTN1 is debounced high: no release pulse, then a fresh press
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 3'b001);
      if (lvl_a[0]) begin n = 1; break; end
    end
    chk("pre_reset_high", {31'd0, n[0]}, 32'd1);
    step(1'b1, 3'b001);
    chk("reset_level", {29'd0, lvl_a}, 32'd0);
    chk("reset_no_release", {29'd0, rel_a}, 32'd0);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 3'b001);
      if (prs_a[0]) begin lat = i; break; end
    end
    chk("redebounce_press_window", {31'd0, (lat >= 9 && lat <= 12)}, 32'd1);
    for (int i = 0; i < 20; i++) step(1'b0, 3'b000);

    // Random activity, including occasional resets, checked by the model
    for (int i = 0; i < 300; i++) begin
      b = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 25);
      for (int j = 0; j < hold; j++) begin
        if ($urandom_range(0, 3) == 0) b[$urandom_range(0, 2)] = ~b[$urandom_range(0, 2)];
        step(($urandom_range(0, 199) == 0), b);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
